boot_loader: RTL and testbench

- Streams a program image into the multicycle core's unified memory before the core starts running.
- Receives a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes the words to memory through a write port muxed in front of the mem block.
- Holds the core in reset until the image is loaded and its checksum matches; then releases the core.

---
 rtl/boot_pkg.sv | 22 ++
 rtl/word_assembler.sv | 30 +++
 rtl/boot_loader.sv | 140 ++++++++++++++
 tb/tb_boot_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and widths for the boot loader: FSM state encoding, counter
// and checksum widths, and the checksum accumulate helper.
package boot_pkg;

  localparam int CSUM_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        data_byte);
    return acc + data_byte;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into 32-bit little-endian words; word_valid fires in the
// same cycle the fourth byte of a word is presented, with the complete word.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_r;
  logic [23:0] shift_r;

  // The fourth byte completes the word directly and never needs storing.
  assign word_valid = byte_valid && (lane_r == 2'd3);
  assign word       = {byte_in, shift_r};

  // Lane counter and low-lane shift register, first byte ending up in [7:0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_r  <= 2'd0;
      shift_r <= 24'd0;
    end else if (byte_valid) begin
      lane_r  <= lane_r + 2'd1;
      shift_r <= {byte_in, shift_r[23:8]};
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams a framed program image into memory and releases the core once the
// checksum matches. Define BOOT_TIMEOUT_EN to abort on long mid-frame idle gaps.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned WORDS_MAX = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
`ifdef BOOT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        err
);

  state_t             state_r, state_n;
  logic [CNT_W-1:0]   count_r, word_idx_r;
  logic [CSUM_W-1:0]  csum_r;
  logic [CNT_W-1:0]   hdr_count_s;
  logic               accept_s, asm_valid_s, word_valid_s, last_word_s, timeout_s;
  logic [31:0]        word_s;

  assign in_ready    = (state_r == CNT_LO) || (state_r == CNT_HI) ||
                       (state_r == DATA)   || (state_r == CSUM);
  assign accept_s    = in_valid && in_ready;
  assign asm_valid_s = accept_s && (state_r == DATA);
  assign hdr_count_s = {in_byte, count_r[7:0]};
  assign last_word_s = word_valid_s && (word_idx_r == (count_r - 16'd1));

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (asm_valid_s),
    .byte_in    (in_byte),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] idle_r;
  logic        waiting_s;

  // CNT_LO is excluded so the loader can wait forever for a frame to begin.
  assign waiting_s = (state_r == CNT_HI) || (state_r == DATA) || (state_r == CSUM);
  assign timeout_s = waiting_s && !accept_s && (idle_r == (TIMEOUT_CYCLES - 32'd1));

  // Idle gap counter, cleared by every accepted byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_r <= 32'd0;
    end else if (accept_s || !waiting_s) begin
      idle_r <= 32'd0;
    end else begin
      idle_r <= idle_r + 32'd1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic for the frame parser.
  always_comb begin
    state_n = state_r;
    case (state_r)
      CNT_LO: begin
        if (accept_s) state_n = CNT_HI;
        else          state_n = CNT_LO;
      end
      CNT_HI: begin
        if (accept_s) begin
          if (32'(hdr_count_s) > WORDS_MAX) state_n = ERR;
          else if (hdr_count_s == 16'd0)    state_n = CSUM;
          else                              state_n = DATA;
        end else if (timeout_s) begin
          state_n = ERR;
        end else begin
          state_n = CNT_HI;
        end
      end
      DATA: begin
        if (last_word_s)    state_n = CSUM;
        else if (timeout_s) state_n = ERR;
        else                state_n = DATA;
      end
      CSUM: begin
        if (accept_s) begin
          if (in_byte == csum_r) state_n = DONE;
          else                   state_n = ERR;
        end else if (timeout_s) begin
          state_n = ERR;
        end else begin
          state_n = CSUM;
        end
      end
      DONE:    state_n = DONE;
      ERR:     state_n = ERR;
      default: state_n = ERR;
    endcase
  end

  // State, datapath and registered outputs; status flags follow the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= CNT_LO;
      count_r    <= 16'd0;
      word_idx_r <= 16'd0;
      csum_r     <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r <= state_n;
      mem_we  <= word_valid_s;
      if (accept_s && (state_r == CNT_LO)) count_r <= {8'd0, in_byte};
      if (accept_s && (state_r == CNT_HI)) count_r <= hdr_count_s;
      if (asm_valid_s) csum_r <= csum_add(csum_r, in_byte);
      if (word_valid_s) begin
        mem_addr   <= BASE_ADDR + {14'd0, word_idx_r, 2'b00};
        mem_wdata  <= word_s;
        word_idx_r <= word_idx_r + 16'd1;
      end
      core_reset <= (state_n != DONE);
      done       <= (state_n == DONE);
      err        <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed, table-driven bench for boot_loader plus hand-written sequences for
// mid-load reset and (with BOOT_TIMEOUT_EN) the idle timeout.
module tb_boot_loader;

  localparam int unsigned WORDS_MAX = 256;
  localparam logic [31:0] BASE      = 32'h0000_0000;
`ifdef BOOT_TIMEOUT_EN
  localparam int unsigned TOUT    = 16;
  localparam int          MAX_GAP = 8;
`else
  localparam int          MAX_GAP = 50;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_ready, mem_we, core_reset, done, err;
  logic [31:0] mem_addr, mem_wdata;

  boot_loader #(
    .WORDS_MAX(WORDS_MAX),
    .BASE_ADDR(BASE)
`ifdef BOOT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TOUT)
`endif
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(core_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        good;       // send the bench-computed checksum instead of csum
    logic [7:0]  csum;
    logic        gaps;
    logic        exp_done;
    logic        exp_err;
    int          exp_writes;
  } frame_t;

  frame_t      frames[10];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        both_seen = 1'b0;
  logic        we_double = 1'b0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (done && err) both_seen = 1'b1;
    if (mem_we && prev_we) we_double = 1'b1;
    prev_we = mem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  function automatic logic [31:0] word_of(input frame_t f, input int k);
    if (k == 0) return f.w0;
    else if (k == 1) return f.w1;
    else return f.w1 + 32'(k);
  endfunction

  task automatic run_frame(input frame_t f, input int idx);
    logic [7:0]  sum;
    logic [31:0] w;
    int          nsend, nchk;
    sum = 8'd0;
    do_reset();
    send_byte(f.n[7:0],  f.gaps ? int'($urandom_range(0, MAX_GAP)) : 0);
    send_byte(f.n[15:8], f.gaps ? int'($urandom_range(0, MAX_GAP)) : 0);
    nsend = (32'(f.n) > WORDS_MAX) ? 0 : int'(f.n);
    for (int k = 0; k < nsend; k++) begin
      w = word_of(f, k);
      for (int b = 0; b < 4; b++) begin
        sum = sum + w[8*b +: 8];
        send_byte(w[8*b +: 8], f.gaps ? int'($urandom_range(0, MAX_GAP)) : 0);
      end
    end
    if (32'(f.n) <= WORDS_MAX) send_byte(f.good ? sum : f.csum, 0);
    #1;
    check($sformatf("f%0d_done", idx), 32'(done), 32'(f.exp_done));
    check($sformatf("f%0d_err", idx), 32'(err), 32'(f.exp_err));
    check($sformatf("f%0d_core_reset", idx), 32'(core_reset), 32'(!f.exp_done));
    check($sformatf("f%0d_in_ready", idx), 32'(in_ready), 32'(0));
    // Bytes offered after termination must be ignored.
    @(negedge clk);
    for (int j = 0; j < 8; j++) send_byte(8'hA5, 0);
    repeat (2) @(negedge clk);
    #1;
    check($sformatf("f%0d_nwrites", idx), 32'(wr_addr_q.size()), 32'(f.exp_writes));
    nchk = (wr_addr_q.size() < f.exp_writes) ? wr_addr_q.size() : f.exp_writes;
    for (int k = 0; k < nchk; k++) begin
      check($sformatf("f%0d_addr%0d", idx, k), wr_addr_q[k], BASE + 32'(4 * k));
      check($sformatf("f%0d_data%0d", idx, k), wr_data_q[k], word_of(f, k));
    end
  endtask

  initial begin
    // n, w0, w1, good, csum, gaps, exp_done, exp_err, exp_writes
    frames[0] = '{16'd2,   32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    frames[1] = '{16'd2,   32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 8'hC9, 1'b0, 1'b0, 1'b1, 2};
    frames[2] = '{16'd2,   32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 8'h4C, 1'b0, 1'b1, 1'b0, 2};
    frames[3] = '{16'd257, 32'h0,         32'h0,         1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    frames[4] = '{16'd0,   32'h0,         32'h0,         1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    frames[5] = '{16'd0,   32'h0,         32'h0,         1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 0};
    frames[6] = '{16'd2,   32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 2};
    frames[7] = '{16'd256, 32'h0102_0304, 32'hA0B0_C0D0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 256};
    frames[8] = '{16'hFFFF, 32'h0,        32'h0,         1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    frames[9] = '{16'd1,   32'hFFFF_FFFF, 32'h0,         1'b0, 8'hFC, 1'b0, 1'b1, 1'b0, 1};

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_frame(frames[i], i);

    // Oversize header: error right after the second header byte.
    do_reset();
    send_byte(8'h01, 0);
    #1;
    check("ovr_hdr1_err", 32'(err), 32'(0));
    @(negedge clk);
    send_byte(8'h01, 0);
    #1;
    check("ovr_hdr2_err", 32'(err), 32'(1));
    @(negedge clk);

    // Reset after 5 data bytes, then a fresh 1-word frame.
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    #1;
    check("mid_pre_wdata", mem_wdata, 32'h4433_2211);
    reset = 1'b0;
    #1;
    check("mid_async_wdata", mem_wdata, 32'd0);
    check("mid_async_core_reset", 32'(core_reset), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hBA, 3);
    send_byte(8'hFE, 0);
    send_byte(8'hCA, 0);
    send_byte(8'h40, 0);
    #1;
    check("mid_done", 32'(done), 32'(1));
    check("mid_core_reset", 32'(core_reset), 32'(0));
    check("mid_nwrites", 32'(wr_addr_q.size()), 32'(1));
    if (wr_addr_q.size() > 0) begin
      check("mid_addr", wr_addr_q[0], BASE);
      check("mid_data", wr_data_q[0], 32'hCAFE_BABE);
    end
    @(negedge clk);

`ifdef BOOT_TIMEOUT_EN
    // A 15-cycle gap is tolerated; a 16-cycle gap in DATA aborts.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 15);
    send_byte(8'h02, 0);
    #1;
    check("to_gap15_err", 32'(err), 32'(0));
    repeat (16) @(negedge clk);
    #1;
    check("to_gap16_err", 32'(err), 32'(1));
    check("to_core_reset", 32'(core_reset), 32'(1));
    @(negedge clk);
`else
    // Without the timeout a long gap mid-word is harmless.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 200);
    send_byte(8'h30, 0);
    send_byte(8'h40, 0);
    send_byte(8'hA0, 0);
    #1;
    check("gap_done", 32'(done), 32'(1));
    check("gap_err", 32'(err), 32'(0));
    if (wr_data_q.size() > 0) check("gap_data", wr_data_q[0], 32'h4030_2010);
    else check("gap_nwrites", 32'(wr_data_q.size()), 32'(1));
    @(negedge clk);
`endif

    check("done_err_exclusive", 32'(both_seen), 32'(0));
    check("we_single_pulse", 32'(we_double), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
